// File: rtl/spi_rx_deframer.sv
// Receive-side deframer for the 8-bit MSB-first serial transmitter.
// Samples bit_in/stop_in every rising edge, rebuilds 8-bit frames, flags
// short/long frames, and buffers good bytes in a first-word-fall-through
// FIFO read over a valid/ready handshake.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bit_in       - serial data (MSB first)
//   stop_in      - 0 = bit transfer in progress, 1 = idle/frame finished
//   data_out     - byte at FIFO head, valid while out_valid=1 (holds when empty)
//   out_valid    - FIFO not empty
//   out_ready    - consumer takes data_out at the next rising edge
//   err_short    - one-cycle pulse: frame ended with fewer than 8 bits
//   err_long     - one-cycle pulse: ninth bit seen before stop_in rose
//   ovf          - one-cycle pulse: complete frame dropped, FIFO full
//   count        - FIFO occupancy, 0..DEPTH
module spi_rx_deframer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bit_in,
  input  logic          stop_in,
  output logic [7:0]    data_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err_short,
  output logic          err_long,
  output logic          ovf,
  output logic [AW:0]   count
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] BITS_PER_FRAME = CW'(DW);
  localparam logic [AW:0]   FULL_CNT       = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_short_q, err_short_d;
  logic            err_long_q, err_long_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   data_out_q, data_out_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            push_req;
  logic            push;
  logic            pop;
  logic            full;

  // Frame FSM: bit collection and short/long detection.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    push_req    = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_in) begin
          shreg_d = {shreg_q[DW-2:0], bit_in};
          cnt_d   = CW'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!stop_in) begin
          if (cnt_q < BITS_PER_FRAME) begin
            shreg_d = {shreg_q[DW-2:0], bit_in};
            cnt_d   = cnt_q + CW'(1);
          end else begin
            err_long_d = 1'b1;
            state_d    = ST_DISCARD;
          end
        end else begin
          if (cnt_q == BITS_PER_FRAME) begin
            push_req = 1'b1;
          end else begin
            err_short_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (stop_in) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO control; a pop on the same edge frees the slot for a push into a full FIFO.
  always_comb begin
    pop         = out_valid_q && out_ready;
    full        = (count_q == FULL_CNT);
    push        = push_req && (!full || pop);
    ovf_d       = push_req && !push;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
    // Registered head: bypass the byte being written when it becomes the head.
    data_out_d  = data_out_q;
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        data_out_d = shreg_q;
      end else begin
        data_out_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_spi_rx_deframer.sv
// Directed self-checking bench for spi_rx_deframer.
module tb_spi_rx_deframer;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       stop_in;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       err_short;
  logic       err_long;
  logic       ovf;
  logic [2:0] count;

  int checks;
  int errors;

  spi_rx_deframer #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .stop_in   (stop_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_short (err_short),
    .err_long  (err_long),
    .ovf       (ovf),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: set inputs, take the edge, settle 1 time unit past it.
  task automatic tick(input logic b, input logic s, input logic r);
    bit_in    = b;
    stop_in   = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Eight bits MSB first, then the stop edge (with out_ready = r_stop).
  task automatic send_frame(input logic [7:0] v, input logic r_stop);
    for (int i = 7; i >= 0; i--) tick(v[i], 1'b0, 1'b0);
    tick(1'b0, 1'b1, r_stop);
  endtask

  task automatic check_idle_flags(input string tag);
    check({tag, "_es"}, 32'(err_short), 32'd0);
    check({tag, "_el"}, 32'(err_long),  32'd0);
    check({tag, "_ovf"}, 32'(ovf),      32'd0);
  endtask

  initial begin
    logic [7:0] exp_b;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    stop_in   = 1'b1;
    out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(data_out),  32'd0);
    check("rst_count", 32'(count),     32'd0);
    check_idle_flags("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b0);

    // Basic frame 0x35 then pop.
    send_frame(8'h35, 1'b0);
    check("f35_valid", 32'(out_valid), 32'd1);
    check("f35_data",  32'(data_out),  32'h35);
    check("f35_count", 32'(count),     32'd1);
    check_idle_flags("f35");
    tick(1'b0, 1'b1, 1'b1);
    check("f35_pop_valid", 32'(out_valid), 32'd0);
    check("f35_pop_count", 32'(count),     32'd0);
    check("f35_hold_data", 32'(data_out),  32'h35);

    // Short frame, then 0xCC.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("short_pre", 32'(err_short), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("short_pulse", 32'(err_short), 32'd1);
    check("short_count", 32'(count),     32'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("short_end", 32'(err_short), 32'd0);
    send_frame(8'hCC, 1'b0);
    check("fcc_data",  32'(data_out), 32'hCC);
    check("fcc_count", 32'(count),    32'd1);
    tick(1'b0, 1'b1, 1'b1);
    check("fcc_pop", 32'(count), 32'd0);

    // Long frame: 0x29 plus three extra bits with stop held low.
    exp_b = 8'h29;
    for (int i = 7; i >= 0; i--) tick(exp_b[i], 1'b0, 1'b0);
    check("long_pre", 32'(err_long), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("long_pulse", 32'(err_long), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("long_end1", 32'(err_long), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("long_end2", 32'(err_long), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("long_count", 32'(count),     32'd0);
    check("long_valid", 32'(out_valid), 32'd0);
    check_idle_flags("long_stop");
    send_frame(8'h5C, 1'b0);
    check("after_long_data", 32'(data_out), 32'h5C);
    tick(1'b0, 1'b1, 1'b1);

    // Fill to full, overflow, drain in order.
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b0);
    check("fill_count", 32'(count),    32'd4);
    check("fill_head",  32'(data_out), 32'h01);
    send_frame(8'h05, 1'b0);
    check("ovf_pulse", 32'(ovf),   32'd1);
    check("ovf_count", 32'(count), 32'd4);
    tick(1'b0, 1'b1, 1'b0);
    check("ovf_end", 32'(ovf), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain1_%0d", k), 32'(data_out), 32'(k));
      tick(1'b0, 1'b1, 1'b1);
    end
    check("drain1_count", 32'(count),     32'd0);
    check("drain1_valid", 32'(out_valid), 32'd0);
    check("drain1_hold",  32'(data_out),  32'h04);

    // Full FIFO, fifth frame lands on the same edge as a pop.
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b0);
    check("full2_count", 32'(count), 32'd4);
    send_frame(8'h05, 1'b1);
    check("pp_ovf",   32'(ovf),      32'd0);
    check("pp_count", 32'(count),    32'd4);
    check("pp_head",  32'(data_out), 32'h02);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("drain2_%0d", k), 32'(data_out), 32'(k));
      tick(1'b0, 1'b1, 1'b1);
    end
    check("drain2_count", 32'(count), 32'd0);

    // Async reset in the middle of a frame, with one byte buffered.
    send_frame(8'h5A, 1'b0);
    check("pre_rst_count", 32'(count), 32'd1);
    exp_b = 8'hA7;
    for (int i = 7; i >= 3; i--) tick(exp_b[i], 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data",  32'(data_out),  32'd0);
    check("arst_count", 32'(count),     32'd0);
    for (int i = 2; i >= 0; i--) tick(exp_b[i], 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    check("post_rst_count", 32'(count), 32'd0);
    check_idle_flags("post_rst");
    tick(1'b0, 1'b1, 1'b0);
    check_idle_flags("post_rst2");
    send_frame(8'h96, 1'b0);
    check("post_rst_data",  32'(data_out),  32'h96);
    check("post_rst_cnt1",  32'(count),     32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
